// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : risc_pkg
// Description : Shared widths, opcode and phase encodings for the VeriRisc
//               instruction sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package risc_pkg;

  localparam int OPW = 3;
  localparam int PHW = 3;

  // Opcode encodings
  localparam logic [OPW-1:0] HLT = 3'd0;
  localparam logic [OPW-1:0] SKZ = 3'd1;
  localparam logic [OPW-1:0] ADD = 3'd2;
  localparam logic [OPW-1:0] AND = 3'd3;
  localparam logic [OPW-1:0] XOR = 3'd4;
  localparam logic [OPW-1:0] LDA = 3'd5;
  localparam logic [OPW-1:0] STO = 3'd6;
  localparam logic [OPW-1:0] JMP = 3'd7;

  // Phase encodings
  localparam logic [PHW-1:0] INST_ADDR  = 3'd0;
  localparam logic [PHW-1:0] INST_FETCH = 3'd1;
  localparam logic [PHW-1:0] INST_LOAD  = 3'd2;
  localparam logic [PHW-1:0] IDLE       = 3'd3;
  localparam logic [PHW-1:0] OP_ADDR    = 3'd4;
  localparam logic [PHW-1:0] OP_FETCH   = 3'd5;
  localparam logic [PHW-1:0] ALU_OP     = 3'd6;
  localparam logic [PHW-1:0] STORE      = 3'd7;

  // Opcodes that read an operand from memory and write the accumulator
  function automatic logic is_aluop(input logic [OPW-1:0] op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage
`default_nettype wire

// File: rtl/risc_phase_counter.sv
`default_nettype none
// ============================================================================
// Module      : risc_phase_counter
// Description : Free-running phase counter with enable; wraps from all-ones
//               back to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module risc_phase_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: advance when enabled, natural modulo-2^WIDTH wrap
  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Count register, cleared immediately by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/risc_controller.sv
`default_nettype none
// ============================================================================
// Module      : risc_controller
// Description : Eight-phase VeriRisc instruction sequencer. Steps the phase
//               counter, holds the sticky halt flag and decodes phase plus
//               opcode into datapath strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module risc_controller
  import risc_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  output logic [PHW-1:0] phase,
  output logic           sel,
  output logic           rd,
  output logic           ld_ir,
  output logic           inc_pc,
  output logic           ld_pc,
  output logic           ld_ac,
  output logic           data_e,
  output logic           wr,
  output logic           halt
);

  logic [PHW-1:0] phase_q;
  logic           halted_q;
  logic           halted_d;
  logic           w_hlt_set;
  logic           w_cnt_en;
  logic           w_aluop;

  assign w_aluop   = is_aluop(opcode);
  // HLT seen in OP_ADDR stops the counter on that same edge so it stays at 4
  assign w_hlt_set = (phase_q == OP_ADDR) && (opcode == HLT) && !halted_q;
  assign halted_d  = halted_q | w_hlt_set;
  assign w_cnt_en  = !halted_d;

  risc_phase_counter #(
    .WIDTH (PHW)
  ) u_phase_counter (
    .clk     (clk),
    .rst     (rst),
    .en_i    (w_cnt_en),
    .count_o (phase_q)
  );

  // Sticky halt flag; only reset clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  // Strobe decode from registered phase and current opcode
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    data_e = 1'b0;
    wr     = 1'b0;
    halt   = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      case (phase_q)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (opcode == HLT);
        end
        OP_FETCH: begin
          rd = w_aluop;
        end
        ALU_OP: begin
          rd     = w_aluop;
          inc_pc = (opcode == SKZ) && zero;
          ld_pc  = (opcode == JMP);
          data_e = (opcode == STO);
        end
        STORE: begin
          rd     = w_aluop;
          ld_ac  = w_aluop;
          ld_pc  = (opcode == JMP);
          wr     = (opcode == STO);
          data_e = (opcode == STO);
        end
        default: begin
          sel = 1'b1;
        end
      endcase
    end
  end

  assign phase = phase_q;

endmodule
`default_nettype wire

// File: tb/tb_risc_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_risc_controller
// Description : Directed self-checking bench for risc_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_risc_controller;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic [2:0] phase;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt;

  int checks;
  int failures;

  // Strobe vector order: sel rd ld_ir inc_pc ld_pc ld_ac data_e wr halt
  logic [8:0] strobes;
  assign strobes = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt};

  risc_controller dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .zero   (zero),
    .phase  (phase),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .data_e (data_e),
    .wr     (wr),
    .halt   (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ph(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s phase observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s strobes observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One full instruction: exp holds ph0..ph7 strobe vectors, zmask bit p is zero during phase p
  task automatic run8(input string name, input logic [2:0] op, input logic [7:0] zmask,
                      input logic [71:0] exp);
    opcode = op;
    for (int p = 0; p < 8; p++) begin
      zero = zmask[p];
      #1;
      chk_ph($sformatf("%s_ph%0d", name, p), phase, 3'(p));
      chk_st($sformatf("%s_ph%0d", name, p), strobes, exp[(7-p)*9 +: 9]);
      step();
    end
  endtask

  localparam logic [35:0] FETCH = {9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000};

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    opcode   = 3'd5;
    zero     = 1'b0;

    // Reset state
    #3;
    chk_ph("reset", phase, 3'd0);
    chk_st("reset", strobes, 9'b100000000);
    #9;
    rst = 1'b0;
    #1;
    chk_ph("post_reset", phase, 3'd0);

    // LDA
    run8("lda", 3'd5, 8'h00, {FETCH, 9'b000100000, 9'b010000000, 9'b010000000, 9'b010001000});
    // STO
    run8("sto", 3'd6, 8'h00, {FETCH, 9'b000100000, 9'b000000000, 9'b000000100, 9'b000000110});
    // SKZ, zero=1 only in Ph6
    run8("skz_z1", 3'd1, 8'b0100_0000, {FETCH, 9'b000100000, 9'b000000000, 9'b000100000, 9'b000000000});
    // SKZ, zero=0 in Ph6 but 1 everywhere else
    run8("skz_z0", 3'd1, 8'b1011_1111, {FETCH, 9'b000100000, 9'b000000000, 9'b000000000, 9'b000000000});
    // JMP
    run8("jmp", 3'd7, 8'hff, {FETCH, 9'b000100000, 9'b000000000, 9'b000010000, 9'b000010000});
    // ADD behaves as an ALU op
    run8("add", 3'd2, 8'h00, {FETCH, 9'b000100000, 9'b010000000, 9'b010000000, 9'b010001000});

    // Asynchronous reset mid-Ph5 of a STO
    opcode = 3'd6;
    zero   = 1'b0;
    for (int p = 0; p < 5; p++) step();
    chk_ph("pre_async_rst", phase, 3'd5);
    #2;
    rst = 1'b1;
    #1;
    chk_ph("async_rst", phase, 3'd0);
    chk_st("async_rst", strobes, 9'b100000000);
    step();
    chk_ph("rst_held", phase, 3'd0);
    chk_st("rst_held", strobes, 9'b100000000);
    #3;
    rst = 1'b0;
    #1;

    // HLT
    opcode = 3'd0;
    for (int p = 0; p < 4; p++) step();
    chk_ph("hlt_ph4", phase, 3'd4);
    chk_st("hlt_ph4", strobes, 9'b000100001);
    for (int i = 0; i < 20; i++) begin
      step();
      opcode = 3'(i);
      zero   = i[0];
      #1;
      chk_ph($sformatf("halted_%0d", i), phase, 3'd4);
      chk_st($sformatf("halted_%0d", i), strobes, 9'b000000001);
    end
    #2;
    rst = 1'b1;
    #1;
    chk_ph("hlt_rst", phase, 3'd0);
    chk_st("hlt_rst", strobes, 9'b100000000);
    step();
    #2;
    rst    = 1'b0;
    opcode = 3'd5;
    step();
    chk_ph("after_hlt_run", phase, 3'd1);
    chk_st("after_hlt_run", strobes, 9'b110000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
